// File: rtl/fast_sched_pkg.sv
// Shared types and constants for the FAST frame scheduler: sequencer state
// encoding, slot geometry and default frame dimensions.
package fast_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One slot per pixel; length is tied to the 16-phase FAST controller.
  localparam int SLOT_LEN = 16;
  localparam int PHASE_W  = $clog2(SLOT_LEN);

  localparam int DEF_IMG_W     = 180;
  localparam int DEF_IMG_H     = 120;
  localparam int DEF_DRAIN_PIX = 4 * DEF_IMG_W + 2;

endpackage

// File: rtl/fast_sram_arbiter.sv
// Combinational single-port SRAM mux: FAST read wins when it owns the slot,
// the host request passes straight through otherwise.
module fast_sram_arbiter
  import fast_sched_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              i_fast_own,
  input  logic [ADDR_W-1:0] i_fast_addr,
  input  logic              i_host_req,
  input  logic [ADDR_W-1:0] i_host_addr,
  output logic              o_host_gnt,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd
);

  always_comb begin
    o_host_gnt = i_host_req;
    o_mem_addr = i_host_addr;
    o_mem_rd   = i_host_req;
    if (i_fast_own) begin
      o_host_gnt = 1'b0;
      o_mem_addr = i_fast_addr;
      o_mem_rd   = 1'b1;
    end
  end

endmodule

// File: rtl/fast_frame_scheduler.sv
// Frame sequencer for the FAST corner pipeline: sweeps pixel slots, drives the
// FAST phase enable and shares the frame SRAM with a host. Optional corner
// counter is enabled by defining FAST_CORNER_COUNT_EN.
module fast_frame_scheduler
  import fast_sched_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int DRAIN_PIX = DEF_DRAIN_PIX,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 12
) (
  input  logic               clock,
  input  logic               nRESET,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  fast_addr,
  output logic               fast_en,
  output logic [PHASE_W-1:0] slot_phase,
  input  logic               host_req,
  input  logic [ADDR_W-1:0]  host_addr,
  output logic               host_gnt,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic               corner_valid,
  output logic [CNT_W-1:0]   corner_cnt,
  output logic [1:0]         dbg_state
);

  localparam logic [ADDR_W-1:0]  TOTAL_M1  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(IMG_W * IMG_H + DRAIN_PIX - 1);
  localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(SLOT_LEN - 1);

  state_t               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
  logic [PHASE_W-1:0]   r_phase, w_phase_nxt;
  logic                 w_start_acc;
  logic                 w_fast_own;

  always_ff @(posedge clock or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // abort dominates every state; start is only honoured from IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_phase_nxt = r_phase;
    w_start_acc = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_addr_nxt  = '0;
      w_phase_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_RUN;
            w_addr_nxt  = '0;
            w_phase_nxt = '0;
            w_start_acc = 1'b1;
          end
        end
        S_RUN, S_DRAIN: begin
          w_phase_nxt = r_phase + 1'b1;
          if (r_phase == PHASE_MAX) begin
            w_phase_nxt = '0;
            if (r_state == S_DRAIN && r_addr == LAST_ADDR) begin
              w_state_nxt = S_DONE;
              w_addr_nxt  = '0;
            end else begin
              w_addr_nxt = r_addr + 1'b1;
              if (r_state == S_RUN && r_addr == TOTAL_M1) w_state_nxt = S_DRAIN;
            end
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign fast_en    = busy;
  assign done       = (r_state == S_DONE);
  assign fast_addr  = r_addr;
  assign slot_phase = r_phase;
  assign dbg_state  = r_state;

  // DRAIN addresses are past the frame, so only RUN claims the SRAM
  assign w_fast_own = (r_state == S_RUN) && (r_phase == '0);

  fast_sram_arbiter #(
    .ADDR_W(ADDR_W)
  ) u_arb (
    .i_fast_own  (w_fast_own),
    .i_fast_addr (r_addr),
    .i_host_req  (host_req),
    .i_host_addr (host_addr),
    .o_host_gnt  (host_gnt),
    .o_mem_addr  (mem_addr),
    .o_mem_rd    (mem_rd)
  );

`ifdef FAST_CORNER_COUNT_EN
  logic [CNT_W-1:0] r_corner_cnt;

  always_ff @(posedge clock or negedge nRESET) begin
    if (!nRESET) begin
      r_corner_cnt <= '0;
    end else if (w_start_acc) begin
      r_corner_cnt <= '0;
    end else if (busy && corner_valid && (r_corner_cnt != '1)) begin
      r_corner_cnt <= r_corner_cnt + 1'b1;
    end
  end

  assign corner_cnt = r_corner_cnt;
`else
  logic w_unused_corner;
  assign w_unused_corner = corner_valid;
  assign corner_cnt      = '0;
`endif

endmodule
